// File: rtl/otter_mem_ctrl.sv
// ============================================================================
//  Module   : otter_mem_ctrl
//  Purpose  : Memory access controller between the OTTER control FSM and a
//             single-port, fixed-latency backing memory. Serves one access at
//             a time (store > load > fetch), stalls the FSM with o_busy,
//             returns the fetched instruction (o_ir) or a size/sign adjusted
//             load value (o_dm_rdata), and builds byte enables for stores.
//  Config   : OTTER_MISALIGN_TRAP_EN - when defined, misaligned half/word
//             loads/stores and misaligned fetches complete at once with
//             o_err = 1 and never reach memory. When undefined, o_err is 0
//             and the offending low address bits are ignored.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_if_rden/i_if_addr           - instruction fetch request
//             i_dm_rden/i_dm_we/i_dm_addr   - data load/store request
//             i_dm_wdata/i_dm_funct3        - store data, size/sign select
//             o_ir/o_dm_rdata               - fetch / load results
//             o_busy/o_done/o_err           - handshake and misalign flag
//             o_m_req/o_m_we/o_m_addr/o_m_be/o_m_wdata, i_m_rdata - memory
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_mem_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_rden,
  input  logic [31:0] i_if_addr,
  input  logic        i_dm_rden,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [2:0]  i_dm_funct3,
  output logic [31:0] o_ir,
  output logic [31:0] o_dm_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_m_req,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [3:0]  o_m_be,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0]  C_K_FETCH = 2'd0;
  localparam logic [1:0]  C_K_LOAD  = 2'd1;
  localparam logic [1:0]  C_K_STORE = 2'd2;
  localparam logic [2:0]  C_LAT     = 3'(LATENCY);
  localparam logic [31:0] C_NOP     = 32'h0000_0013;

  state_t      r_state;
  logic [1:0]  r_kind;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [3:0]  r_m_be;
  logic [31:0] r_m_wdata;
  logic [31:0] r_ir;
  logic [31:0] r_dm_rdata;

  // --------------------------------------------------------------------------
  // Request arbitration: store beats load beats fetch.
  // --------------------------------------------------------------------------
  logic        w_sel_store;
  logic        w_sel_load;
  logic        w_sel_fetch;
  logic        w_any;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic        w_misalign;

  assign w_sel_store = i_dm_we;
  assign w_sel_load  = ~i_dm_we & i_dm_rden;
  assign w_sel_fetch = ~i_dm_we & ~i_dm_rden & i_if_rden;
  assign w_any       = i_dm_we | i_dm_rden | i_if_rden;
  assign w_addr      = (i_dm_we | i_dm_rden) ? i_dm_addr : i_if_addr;
  assign w_size      = i_dm_funct3[1:0];

`ifdef OTTER_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_sel_fetch)
      w_misalign = |i_if_addr[1:0];
    else if (w_size == 2'b01)
      w_misalign = i_dm_addr[0];
    else if (w_size[1])
      w_misalign = |i_dm_addr[1:0];
  end
`else
  // Misaligned accesses are forced to natural alignment by the lane logic.
  assign w_misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Store lane steering. Half-word lane uses addr[1] only, which also gives
  // natural alignment when addr[0] is set.
  // --------------------------------------------------------------------------
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = i_dm_wdata;
    case (w_size)
      2'b00: begin
        w_st_be    = 4'b0001 << i_dm_addr[1:0];
        w_st_wdata = {4{i_dm_wdata[7:0]}};
      end
      2'b01: begin
        w_st_be    = i_dm_addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{i_dm_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load lane extraction and extension from the registered access info.
  // --------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  always_comb begin
    case (r_addr_lo)
      2'd0:    w_ld_byte = i_m_rdata[7:0];
      2'd1:    w_ld_byte = i_m_rdata[15:8];
      2'd2:    w_ld_byte = i_m_rdata[23:16];
      default: w_ld_byte = i_m_rdata[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? i_m_rdata[31:16] : i_m_rdata[15:0];
    case (r_funct3[1:0])
      2'b00:   w_ld_data = r_funct3[2] ? {24'h0, w_ld_byte}
                                       : {{24{w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = r_funct3[2] ? {16'h0, w_ld_half}
                                       : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = i_m_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Access FSM with registered outputs. Async reset aborts any access.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_kind     <= C_K_FETCH;
      r_funct3   <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_cnt      <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= 32'h0;
      r_m_be     <= 4'h0;
      r_m_wdata  <= 32'h0;
      r_ir       <= C_NOP;
      r_dm_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_kind    <= w_sel_store ? C_K_STORE :
                         (w_sel_load ? C_K_LOAD : C_K_FETCH);
            r_funct3  <= i_dm_funct3;
            r_addr_lo <= w_addr[1:0];
            r_busy    <= 1'b1;
            if (w_misalign) begin
              // Trapped access: straight to the response, memory untouched.
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state  <= S_ISSUE;
              r_m_req  <= 1'b1;
              r_m_addr <= {w_addr[31:2], 2'b00};
              r_m_we   <= w_sel_store;
              r_m_be   <= w_sel_store ? w_st_be : 4'b1111;
              if (w_sel_store)
                r_m_wdata <= w_st_wdata;
            end
          end
        end
        S_ISSUE: begin
          r_m_req <= 1'b0;
          if (r_kind == C_K_STORE) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_cnt   <= C_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // This edge takes the counter to zero: read data is valid now.
          if (r_cnt == 3'd1) begin
            if (r_kind == C_K_FETCH)
              r_ir <= i_m_rdata;
            else
              r_dm_rdata <= w_ld_data;
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_m_we  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ir       = r_ir;
  assign o_dm_rdata = r_dm_rdata;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_m_req    = r_m_req;
  assign o_m_we     = r_m_we;
  assign o_m_addr   = r_m_addr;
  assign o_m_be     = r_m_be;
  assign o_m_wdata  = r_m_wdata;

endmodule

`default_nettype wire

// File: tb/tb_otter_mem_ctrl.sv
// ============================================================================
//  Module   : tb_otter_mem_ctrl
//  Purpose  : Self-checking bench for otter_mem_ctrl. A fixed-latency memory
//             model serves the DUT; a byte-array reference model computes the
//             expected fetch/load results, byte enables and lane data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_otter_mem_ctrl;

  localparam int LAT = 2;
`ifdef OTTER_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_rden, dm_rden, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [2:0]  dm_funct3;
  logic [31:0] ir, dm_rdata, m_addr, m_wdata, m_rdata;
  logic        busy, done, err, m_req, m_we;
  logic [3:0]  m_be;

  otter_mem_ctrl #(.LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_rden(if_rden), .i_if_addr(if_addr),
    .i_dm_rden(dm_rden), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_funct3(dm_funct3),
    .o_ir(ir), .o_dm_rdata(dm_rdata), .o_busy(busy), .o_done(done),
    .o_err(err), .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr),
    .o_m_be(m_be), .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- memory environment (2 KB) ----------------
  logic [7:0]  refm  [2048];
  logic [31:0] mem_w [512];
  logic        mem_load = 1'b0;
  int          pend_cnt = 0;
  logic [8:0]  pend_idx;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++)
        mem_w[i] <= {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]};
    end else if (m_req && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem_w[m_addr[10:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    if (m_req && !m_we) begin
      pend_cnt <= LAT;
      pend_idx <= m_addr[10:2];
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  // Read data is only valid in the cycle before the LATENCY-th edge.
  assign m_rdata = (pend_cnt == 1) ? mem_w[pend_idx] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] exp_ir, exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_read(input int a, input int n, input bit uns);
    int base = a - (a % n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(refm[base+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // ---------------- access driver + checker ----------------
  int          done_cyc, mreq_cyc, mreq_cnt;
  logic        got_err;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic        busy_hist [40];

  task automatic run_check(input int kind, input int a, input logic [31:0] wd,
                           input logic [2:0] f3, input bit with_fetch, input string tag);
    int          n     = (kind == 0) ? 4 : nbytes(f3);
    int          base  = a - (a % n);
    bit          mis   = TRAP && ((a % n) != 0);
    logic [31:0] addr  = 32'(a);
    logic [3:0]  e_be  = 4'b0000;
    logic [31:0] e_wd;
    int          e_done;

    @(posedge clk); #1;
    case (kind)
      0:       begin if_rden = 1'b1; if_addr = addr; end
      1:       begin dm_rden = 1'b1; dm_addr = addr; dm_funct3 = f3; end
      default: begin dm_we = 1'b1; dm_addr = addr; dm_wdata = wd; dm_funct3 = f3; end
    endcase
    if (with_fetch) begin if_rden = 1'b1; if_addr = 32'h100; end

    done_cyc = -1; mreq_cyc = -1; mreq_cnt = 0; got_err = 1'b0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      busy_hist[c] = busy;
      if (m_req) begin
        mreq_cnt++;
        if (mreq_cyc < 0) begin
          mreq_cyc = c; cap_addr = m_addr; cap_be = m_be; cap_wd = m_wdata; cap_we = m_we;
        end
      end
      if (done) begin done_cyc = c; got_err = err; end
    end
    @(posedge clk); #1;
    if_rden = 1'b0; dm_rden = 1'b0; dm_we = 1'b0;

    e_done = mis ? 1 : ((kind == 2) ? 2 : LAT + 2);
    check({tag, ":done_cyc"}, 32'(done_cyc), 32'(e_done));
    check({tag, ":err"}, 32'(got_err), 32'(mis));
    check({tag, ":mreq_cnt"}, 32'(mreq_cnt), mis ? 32'd0 : 32'd1);
    if (!mis && mreq_cnt > 0) begin
      check({tag, ":mreq_cyc"}, 32'(mreq_cyc), 32'd1);
      check({tag, ":m_addr"}, cap_addr, {addr[31:2], 2'b00});
      check({tag, ":m_we"}, 32'(cap_we), 32'(kind == 2));
      for (int i = base; i < base + n; i++) e_be[i % 4] = 1'b1;
      check({tag, ":m_be"}, 32'(cap_be), (kind == 2) ? 32'(e_be) : 32'hF);
      if (kind == 2) begin
        for (int b = 0; b < 4; b++) e_wd[8*b +: 8] = wd[8*(b % n) +: 8];
        check({tag, ":m_wdata"}, cap_wd, e_wd);
      end
    end
    if (!mis) begin
      case (kind)
        0:       exp_ir = ref_read(a, 4, 1'b1);
        1:       exp_rd = ref_read(a, n, f3[2]);
        default: for (int i = 0; i < n; i++) refm[base+i] = wd[8*i +: 8];
      endcase
    end
    check({tag, ":ir"}, ir, exp_ir);
    check({tag, ":dm_rdata"}, dm_rdata, exp_rd);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic        seen;
    logic [31:0] wd;
    rst_n = 1'b0; if_rden = 1'b0; dm_rden = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_funct3 = 3'b000;
    for (int i = 0; i < 2048; i++) refm[i] = 8'($urandom);
    {refm[259], refm[258], refm[257], refm[256]} = 32'h0050_0093;
    {refm[515], refm[514], refm[513], refm[512]} = 32'h80FF_1234;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:ir", ir, 32'h0000_0013);
    check("rst:dm_rdata", dm_rdata, 32'h0);
    check("rst:busy", 32'(busy), 32'h0);
    check("rst:done", 32'(done), 32'h0);
    check("rst:err", 32'(err), 32'h0);
    check("rst:m_req", 32'(m_req), 32'h0);
    check("rst:m_we", 32'(m_we), 32'h0);
    check("rst:m_addr", m_addr, 32'h0);
    check("rst:m_be", 32'(m_be), 32'h0);
    check("rst:m_wdata", m_wdata, 32'h0);
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
    rst_n = 1'b1;
    exp_ir = 32'h0000_0013; exp_rd = 32'h0;

    // Fetch 0x100
    run_check(0, 'h100, 32'h0, 3'b010, 1'b0, "fetch100");
    check("fetch100:ir_const", ir, 32'h0050_0093);
    check("fetch100:busy_hist", 32'({busy_hist[4], busy_hist[3], busy_hist[2],
                                      busy_hist[1], busy_hist[0]}), 32'b11110);

    // Byte loads, signed and unsigned
    run_check(1, 'h203, 32'h0, 3'b000, 1'b0, "lb203");
    check("lb203:const", dm_rdata, 32'hFFFF_FF80);
    run_check(1, 'h203, 32'h0, 3'b100, 1'b0, "lbu203");
    check("lbu203:const", dm_rdata, 32'h0000_0080);

    // Store half
    run_check(2, 'h302, 32'hABCD_5678, 3'b001, 1'b0, "sh302");
    check("sh302:be_const", 32'(cap_be), 32'hC);
    check("sh302:wd_const", cap_wd, 32'h5678_5678);

    // Store and fetch together: store wins, fetch needs re-assertion
    wd = $urandom;
    run_check(2, 'h010, wd, 3'b010, 1'b1, "prio");
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (busy) seen = 1'b1; end
    check("prio:idle_after", 32'(seen), 32'h0);
    run_check(0, 'h010, 32'h0, 3'b010, 1'b0, "prio_fetch");
    check("prio_fetch:ir", ir, wd);

    // Misaligned word load
    run_check(1, 'h402, 32'h0, 3'b010, 1'b0, "lw402");

    // Reset during ISSUE (phase 1) and WAIT (phase 2)
    for (int ph = 1; ph <= 2; ph++) begin
      @(posedge clk); #1;
      if_rden = 1'b1; if_addr = 32'h104;
      repeat (ph + 1) @(negedge clk);
      check($sformatf("abort%0d:busy_before", ph), 32'(busy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check($sformatf("abort%0d:m_req", ph), 32'(m_req), 32'h0);
      check($sformatf("abort%0d:busy", ph), 32'(busy), 32'h0);
      check($sformatf("abort%0d:ir", ph), ir, 32'h0000_0013);
      if_rden = 1'b0;
      @(negedge clk); #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (done) seen = 1'b1; end
      check($sformatf("abort%0d:no_done", ph), 32'(seen), 32'h0);
      check($sformatf("abort%0d:ir_after", ph), ir, 32'h0000_0013);
    end
    exp_ir = 32'h0000_0013; exp_rd = 32'h0;

    // Randomized accesses in a small window so stores and loads overlap
    for (int k = 0; k < 60; k++) begin
      run_check(int'($urandom_range(0, 2)), int'($urandom_range(0, 63)), $urandom,
                3'($urandom), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
